// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Sequences a multi-bit shift/rotate as single-bit steps through
//               an external combinational ALU. Define SHIFT_COUNT_MASK_EN to
//               use only count[4:0] (80186 style); otherwise count[7:0] is used.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  shift_op,
    input  logic        is_8_bit,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    input  logic [15:0] flags_in,
    input  logic        flush,
    output logic [2:0]  alu_op,
    output logic        alu_is_8_bit,
    output logic [15:0] alu_a,
    output logic [4:0]  alu_shift_count,
    output logic        alu_multibit_shift,
    output logic [15:0] alu_flags,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_flags_out,
    output logic [15:0] result,
    output logic [15:0] flags_out,
    output logic        busy,
    output logic        done
);

`ifdef SHIFT_COUNT_MASK_EN
    localparam int CNT_W = 5;
    logic w_unused_count;
    assign w_unused_count = ^count[7:5];
`else
    localparam int CNT_W = 8;
`endif

    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_shift = 2'd1;
    localparam logic [1:0]       c_done  = 2'd2;
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic             r_is_8_bit;
    logic [15:0]      r_value;
    logic [15:0]      r_flags;
    logic [CNT_W-1:0] r_remaining;

    logic [CNT_W-1:0] w_eff_count;
    logic [2:0]       w_op;

    assign w_eff_count = count[CNT_W-1:0];
    // Reserved encoding 7 is latched as SHL so the ALU only ever sees defined ops.
    assign w_op        = (shift_op == 3'd7) ? 3'd0 : shift_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_idle;
            r_op        <= 3'd0;
            r_is_8_bit  <= 1'b0;
            r_value     <= 16'h0000;
            r_flags     <= 16'h0000;
            r_remaining <= '0;
        end else if (flush) begin
            r_state <= c_idle;
        end else begin
            case (r_state)
                c_shift: begin
                    r_value <= r_is_8_bit ? {r_value[15:8], alu_out[7:0]} : alu_out;
                    r_flags <= alu_flags_out;
                    if (r_remaining != '0) begin
                        r_remaining <= r_remaining - c_one;
                    end
                    if (r_remaining <= c_one) begin
                        r_state <= c_done;
                    end
                end
                c_idle, c_done: begin
                    if (start) begin
                        r_op        <= w_op;
                        r_is_8_bit  <= is_8_bit;
                        r_value     <= operand;
                        r_flags     <= flags_in;
                        r_remaining <= w_eff_count;
                        r_state     <= (w_eff_count == '0) ? c_done : c_shift;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign alu_op             = r_op;
    assign alu_is_8_bit       = r_is_8_bit;
    assign alu_a              = r_value;
    assign alu_flags          = r_flags;
    assign alu_shift_count    = (r_state == c_shift) ? 5'd1 : 5'd0;
    assign alu_multibit_shift = 1'b0;
    assign result             = r_value;
    assign flags_out          = r_flags;
    assign busy               = (r_state == c_shift);
    assign done               = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer with a behavioural ALU
//               and a whole-sequence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  shift_op;
    logic        is_8_bit;
    logic [15:0] operand;
    logic [7:0]  count;
    logic [15:0] flags_in;
    logic        flush;
    logic [2:0]  alu_op;
    logic        alu_is_8_bit;
    logic [15:0] alu_a;
    logic [4:0]  alu_shift_count;
    logic        alu_multibit_shift;
    logic [15:0] alu_flags;
    logic [15:0] alu_out;
    logic [15:0] alu_flags_out;
    logic [15:0] result;
    logic [15:0] flags_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .shift_op           (shift_op),
        .is_8_bit           (is_8_bit),
        .operand            (operand),
        .count              (count),
        .flags_in           (flags_in),
        .flush              (flush),
        .alu_op             (alu_op),
        .alu_is_8_bit       (alu_is_8_bit),
        .alu_a              (alu_a),
        .alu_shift_count    (alu_shift_count),
        .alu_multibit_shift (alu_multibit_shift),
        .alu_flags          (alu_flags),
        .alu_out            (alu_out),
        .alu_flags_out      (alu_flags_out),
        .result             (result),
        .flags_out          (flags_out),
        .busy               (busy),
        .done               (done)
    );

    // One-bit shift/rotate on the low 8 or 16 bits; CF is flags bit 0.
    // In 8-bit mode the upper byte is deliberately corrupted.
    function automatic logic [31:0] alu_step(input logic [2:0] op, input logic is8,
                                             input logic [15:0] a, input logic [15:0] f);
        logic [31:0] v, top, m, r;
        logic        msb, lsb, cf;
        m   = is8 ? 32'h0000_00ff : 32'h0000_ffff;
        top = is8 ? 32'h0000_0080 : 32'h0000_8000;
        v   = {16'h0000, a} & m;
        msb = ((v & top) != 32'h0);
        lsb = v[0];
        case (op)
            3'd1:    begin r = v >> 1;                              cf = lsb; end
            3'd2:    begin r = (v >> 1) | (msb ? top : 32'h0);      cf = lsb; end
            3'd3:    begin r = (v << 1) | {31'h0, msb};             cf = msb; end
            3'd4:    begin r = (v >> 1) | (lsb ? top : 32'h0);      cf = lsb; end
            3'd5:    begin r = (v << 1) | {31'h0, f[0]};            cf = msb; end
            3'd6:    begin r = (v >> 1) | (f[0] ? top : 32'h0);     cf = lsb; end
            default: begin r = v << 1;                              cf = msb; end
        endcase
        r = r & m;
        if (is8) r[15:8] = ~a[15:8];
        return {r[15:0], f[15:1], cf};
    endfunction

    always_comb {alu_out, alu_flags_out} = alu_step(alu_op, alu_is_8_bit, alu_a, alu_flags);

    function automatic int eff(input logic [7:0] c);
`ifdef SHIFT_COUNT_MASK_EN
        return int'(c & 8'h1f);
`else
        return int'(c);
`endif
    endfunction

    task automatic ref_seq(input logic [2:0] op, input logic is8, input logic [15:0] opnd,
                           input logic [15:0] fl, input int n,
                           output logic [15:0] er, output logic [15:0] ef);
        logic [31:0] s;
        er = opnd;
        ef = fl;
        for (int i = 0; i < n; i++) begin
            s  = alu_step(op, is8, er, ef);
            er = s[31:16];
            ef = s[15:0];
        end
        if (is8) er[15:8] = opnd[15:8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic is8, input logic [15:0] opnd,
                          input logic [7:0] cnt, input logic [15:0] fl);
        shift_op = op;
        is_8_bit = is8;
        operand  = opnd;
        count    = cnt;
        flags_in = fl;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Called in the cycle numbered cyc0 after the accepting edge; returns in the done cycle.
    task automatic wait_done(input string tag, input int n, input logic [15:0] er,
                             input logic [15:0] ef, input logic [2:0] eop, input logic eis8,
                             input int cyc0);
        int cyc;
        cyc = cyc0;
        while (done !== 1'b1 && cyc <= 300) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_alu_cnt"}, 32'(alu_shift_count), 32'd1);
            check({tag, "_alu_op"}, {28'h0, alu_is_8_bit, alu_op}, {28'h0, eis8, eop});
            tick();
            cyc++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_flags"}, 32'(flags_out), 32'(ef));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_seq(input string tag, input logic [2:0] op, input logic is8,
                           input logic [15:0] opnd, input logic [7:0] cnt, input logic [15:0] fl);
        int          n;
        logic [15:0] er, ef;
        n = eff(cnt);
        ref_seq(op, is8, opnd, fl, n, er, ef);
        launch(op, is8, opnd, cnt, fl);
        wait_done(tag, n, er, ef, (op == 3'd7) ? 3'd0 : op, is8, 1);
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_flags"}, 32'(flags_out), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_flags"}, 32'(alu_flags), 32'd0);
        check({tag, "_alu_ctl"},
              {21'h0, alu_op, alu_is_8_bit, alu_shift_count, alu_multibit_shift}, 32'd0);
    endtask

    initial begin
        logic [15:0] era, efa, erb, efb;
        reset_n  = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        shift_op = 3'd0;
        is_8_bit = 1'b0;
        operand  = 16'h0;
        count    = 8'h0;
        flags_in = 16'h0;
        tick();
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // SHL 8-bit 0x0081 by 3 -> 0x0008, CF=0
        run_seq("shl8", 3'd0, 1'b1, 16'h0081, 8'd3, 16'h0000);
        check("shl8_const", 32'(result), 32'h0008);
        check("shl8_cf", 32'(flags_out[0]), 32'd0);

        // ROR count 0: latency 1, operand/flags pass through
        run_seq("ror0", 3'd4, 1'b0, 16'h1234, 8'd0, 16'h0001);
        check("ror0_const", {result, flags_out}, 32'h1234_0001);

        // SHR count 33: masked -> one shift, unmasked -> 33 shifts
        run_seq("shr33", 3'd1, 1'b0, 16'h8000, 8'd33, 16'h0000);
`ifdef SHIFT_COUNT_MASK_EN
        check("shr33_const", 32'(result), 32'h4000);
`else
        check("shr33_const", 32'(result), 32'h0000);
`endif

        // Long count and reserved op
        run_seq("rcl200", 3'd5, 1'b0, 16'hbeef, 8'd200, 16'h0001);
        run_seq("op7", 3'd7, 1'b1, 16'h3c5a, 8'd4, 16'h0000);

        for (int i = 0; i < 25; i++) begin
            run_seq("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    16'($urandom), 8'($urandom_range(0, 40)), 16'($urandom));
        end

        // Start during SHIFT ignored; start on done cycle runs back-to-back
        ref_seq(3'd3, 1'b0, 16'h1234, 16'h0000, 4, era, efa);
        ref_seq(3'd6, 1'b1, 16'ha5c3, 16'h0001, 6, erb, efb);
        launch(3'd3, 1'b0, 16'h1234, 8'd4, 16'h0000);
        tick();
        shift_op = 3'd1;
        operand  = 16'hffff;
        count    = 8'd9;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done("b2b_a", 4, era, efa, 3'd3, 1'b0, 3);
        shift_op = 3'd6;
        is_8_bit = 1'b1;
        operand  = 16'ha5c3;
        count    = 8'd6;
        flags_in = 16'h0001;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done("b2b_b", 6, erb, efb, 3'd6, 1'b1, 1);
        tick();
        check("b2b_idle", 32'(done), 32'd0);

        // Flush mid-sequence: IDLE next cycle, no done pulse
        launch(3'd2, 1'b0, 16'h8001, 8'd5, 16'h0000);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("flush_no_done", {30'h0, busy, done}, 32'd0);
        end

        // Flush beats a simultaneous start
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start", {30'h0, busy, done}, 32'd0);

        // Asynchronous reset mid-sequence
        launch(3'd2, 1'b0, 16'hf00f, 8'd5, 16'hffff);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        run_seq("after_reset", 3'd0, 1'b1, 16'h0081, 8'd3, 16'h0000);
        check("after_reset_const", 32'(result), 32'h0008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
